// File: rtl/solver_ram_pkg.sv
// Shared definitions for the solver dual-port on-chip RAM.
//   RD_LAT_MIN / RD_LAT_MAX : supported read latencies
//   port_req_t              : decoded Avalon-MM request flags of one slave port
//   byte_parity()           : even-parity bit of one byte
package solver_ram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
  } port_req_t;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/solver_ram_rd_pipe.sv
// Read-return pipeline for one RAM port.
//   clk, srst  : clock, synchronous active-high reset (flushes the pipeline)
//   en         : advance enable; when low every stage holds and rd_valid is masked
//   acc        : a read was accepted this cycle
//   oor        : the accepted read's address is out of range (data returned as 0)
//   raw_data   : registered array output, valid the cycle after acceptance
//   rd_data    : returned word, meaningful only with rd_valid
//   rd_valid   : one pulse per accepted read, LAT enabled cycles after acceptance
module solver_ram_rd_pipe
  import solver_ram_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  input  logic         acc,
  input  logic         oor,
  input  logic [W-1:0] raw_data,
  output logic [W-1:0] rd_data,
  output logic         rd_valid
);

  logic valid1_reg;
  logic oor1_reg;

  // First stage lines up with the array's registered read.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid1_reg <= 1'b0;
      oor1_reg   <= 1'b0;
    end else if (en) begin
      valid1_reg <= acc;
      oor1_reg   <= oor;
    end
  end

  generate
    if (LAT == RD_LAT_MIN) begin : g_lat1
      assign rd_data  = oor1_reg ? '0 : raw_data;
      assign rd_valid = valid1_reg & en & ~srst;
    end else begin : g_lat2
      logic         valid2_reg;
      logic [W-1:0] data2_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          valid2_reg <= 1'b0;
          data2_reg  <= '0;
        end else if (en) begin
          valid2_reg <= valid1_reg;
          data2_reg  <= oor1_reg ? '0 : raw_data;
        end
      end

      assign rd_data  = data2_reg;
      assign rd_valid = valid2_reg & en & ~srst;
    end
  endgenerate

endmodule

// File: rtl/solver_onchip_ram_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves (s1 = CPU, s2 = DMA).
//   clk, reset           : clock, synchronous active-high reset (array contents kept)
//   reset_req, clken     : the RAM advances only when clken=1 and reset_req=0
//   s{1,2}_chipselect/read/write/address/byteenable/writedata : request inputs
//   s{1,2}_readdata/readdatavalid : pipelined read return
//   s{1,2}_waitrequest   : request not accepted this cycle (only s2 ever stalls,
//                          on a same-address write collision with s1)
//   parity_err           : sticky parity error flag
// Optional feature: define ONCHIP_RAM_PARITY_EN to store one even-parity bit per
// byte plus a per-word written flag, checked on every returned read.
module solver_onchip_ram_dp
  import solver_ram_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 6000,
  parameter int    ADDR_W       = 13,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "solver_onchip_RAM.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clken,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                parity_err
);

  localparam int NB = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
  // Word layout: {written_flag, parity[NB-1:0], data[DATA_W-1:0]}
  localparam int MEM_W = DATA_W + NB + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  (* ram_init_file = INIT_FILE *) logic [MEM_W-1:0] mem [DEPTH];

  port_req_t         req [2];
  logic [ADDR_W-1:0] addr [2];
  logic [NB-1:0]     be [2];
  logic [DATA_W-1:0] wd [2];
  logic [1:0]        in_range;
  logic [1:0]        acc_rd;
  logic [1:0]        acc_wr;
  logic [MEM_W-1:0]  raw_reg [2];
  logic [MEM_W-1:0]  pipe_data [2];
  logic [1:0]        pipe_valid;
  logic              active;
  logic              collide;
  logic              s2_stalled_reg;

  assign req[0]  = '{sel: s1_chipselect, rd: s1_read, wr: s1_write};
  assign req[1]  = '{sel: s2_chipselect, rd: s2_read, wr: s2_write};
  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign be[0]   = s1_byteenable;
  assign be[1]   = s2_byteenable;
  assign wd[0]   = s1_writedata;
  assign wd[1]   = s2_writedata;

  assign active = clken & ~reset_req;

  // s2 loses a same-address write collision once; the stalled flag then lets
  // the held s2 write through on the following enabled cycle.
  assign collide = active & req[0].sel & req[0].wr & req[1].sel & req[1].wr &
                   (addr[0] == addr[1]) & in_range[0] & ~s2_stalled_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign in_range[gi] = {1'b0, addr[gi]} < DEPTH_X;
      // read & write together: the write wins and the read is discarded
      assign acc_rd[gi] = active & req[gi].sel & req[gi].rd & ~req[gi].wr;

      solver_ram_rd_pipe #(
        .W   (MEM_W),
        .LAT (READ_LATENCY)
      ) u_rd_pipe (
        .clk      (clk),
        .srst     (reset),
        .en       (active),
        .acc      (acc_rd[gi]),
        .oor      (~in_range[gi]),
        .raw_data (raw_reg[gi]),
        .rd_data  (pipe_data[gi]),
        .rd_valid (pipe_valid[gi])
      );
    end
  endgenerate

  assign acc_wr[0] = active & req[0].sel & req[0].wr;
  assign acc_wr[1] = active & req[1].sel & req[1].wr & ~collide;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_stalled_reg <= 1'b0;
    end else if (active) begin
      s2_stalled_reg <= collide;
    end
  end

  // While frozen the last arbitration result is presented unchanged.
  assign s1_waitrequest = 1'b0;
  assign s2_waitrequest = ~reset & (active ? collide : s2_stalled_reg);

`ifdef ONCHIP_RAM_PARITY_EN
  logic [NB-1:0] wr_par [2];
  logic [NB-1:0] rd_par [2];
  logic [1:0]    par_bad;
  logic          parity_err_reg;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_par[p] = '0;
      rd_par[p] = '0;
      for (int b = 0; b < NB; b++) begin
        wr_par[p][b] = byte_parity(wd[p][8*b +: 8]);
        rd_par[p][b] = byte_parity(pipe_data[p][8*b +: 8]);
      end
      // Words never written since power-up carry no valid parity.
      par_bad[p] = pipe_valid[p] & pipe_data[p][MEM_W-1] &
                   (pipe_data[p][DATA_W +: NB] != rd_par[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_reg <= 1'b0;
    end else if (|par_bad) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign parity_err = parity_err_reg | (|par_bad);
`else
  assign parity_err = 1'b0;
`endif

  // Array write port logic. Port 1 is applied after port 0 so s2 is last writer.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc_wr[p] && in_range[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) begin
            mem[addr[p]][8*b +: 8] <= wd[p][8*b +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            mem[addr[p]][DATA_W + b] <= wr_par[p][b];
            mem[addr[p]][MEM_W-1]    <= 1'b1;
`endif
          end
        end
      end
    end
  end

  // Registered reads see the pre-write contents (old-data read-during-write).
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        raw_reg[p] <= '0;
      end else if (acc_rd[p] && in_range[p]) begin
        raw_reg[p] <= mem[addr[p]];
      end
    end
  end

  assign s1_readdata      = pipe_data[0][DATA_W-1:0];
  assign s2_readdata      = pipe_data[1][DATA_W-1:0];
  assign s1_readdatavalid = pipe_valid[0];
  assign s2_readdatavalid = pipe_valid[1];

endmodule

// File: tb/tb_solver_onchip_ram_dp.sv
// Randomized + directed bench for solver_onchip_ram_dp against a queue/array model.
module tb_solver_onchip_ram_dp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 6000;
  localparam int ADDR_W = 13;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        reset, reset_req, clken;
  logic        s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [12:0] s1_addr, s2_addr;
  logic [3:0]  s1_be, s2_be;
  logic [31:0] s1_wd, s2_wd;
  logic [31:0] s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest;
  logic        parity_err;

  always #5 clk = ~clk;

  solver_onchip_ram_dp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(LAT),
    .INIT_FILE("solver_onchip_RAM.hex")
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
    .s1_address(s1_addr), .s1_byteenable(s1_be), .s1_writedata(s1_wd),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
    .s2_address(s2_addr), .s2_byteenable(s2_be), .s2_writedata(s2_wd),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .s2_waitrequest(s2_waitrequest),
    .parity_err(parity_err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    int          cnt;   // enabled cycles elapsed since acceptance
  } rd_ent_t;

  logic [31:0] model_mem [DEPTH];
  rd_ent_t     q1[$], q2[$];
  bit          prev_stall;
  logic [31:0] last1, last2;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [12:0] a);
    return (a < DEPTH) ? model_mem[a] : 32'h0;
  endfunction

  function automatic void model_write(input logic [12:0] a, input logic [3:0] be,
                                      input logic [31:0] d);
    if (a < DEPTH)
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic set_idle();
    s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_addr = 0; s1_be = 0; s1_wd = 0;
    s2_cs = 0; s2_rd = 0; s2_wr = 0; s2_addr = 0; s2_be = 0; s2_wd = 0;
  endtask

  // Inputs are already driven (posedge+1); settle, check, update model, advance.
  task automatic do_cycle();
    bit act, s1w, s1r, s2w, s2r, coll, ev1, ev2;
    logic [31:0] r1, r2;
    #1;
    if (reset) begin
      q1.delete(); q2.delete(); prev_stall = 0;
      @(posedge clk); #1;
      return;
    end
    act  = clken && !reset_req;
    s1w  = s1_cs && s1_wr;
    s1r  = s1_cs && s1_rd && !s1_wr;
    s2w  = s2_cs && s2_wr;
    s2r  = s2_cs && s2_rd && !s2_wr;
    coll = act && s1w && s2w && (s1_addr == s2_addr) && (s1_addr < DEPTH) && !prev_stall;
    check("s1_wait", s1_waitrequest, 0);
    check("s2_wait", s2_waitrequest, act ? coll : prev_stall);
    if (act) begin
      foreach (q1[i]) q1[i].cnt++;
      foreach (q2[i]) q2[i].cnt++;
    end
    ev1 = act && q1.size() > 0 && q1[0].cnt == LAT;
    ev2 = act && q2.size() > 0 && q2[0].cnt == LAT;
    check("s1_valid", s1_readdatavalid, ev1);
    check("s2_valid", s2_readdatavalid, ev2);
    if (ev1) begin
      check("s1_data", s1_readdata, q1[0].data);
      last1 = s1_readdata;
      $display("rd s1 data=%h exp=%h", s1_readdata, q1[0].data);
      void'(q1.pop_front());
    end
    if (ev2) begin
      check("s2_data", s2_readdata, q2[0].data);
      last2 = s2_readdata;
      $display("rd s2 data=%h exp=%h", s2_readdata, q2[0].data);
      void'(q2.pop_front());
    end
    if (act) begin
      r1 = model_read(s1_addr);
      r2 = model_read(s2_addr);
      if (s1r) q1.push_back('{data: r1, cnt: 0});
      if (s2r) q2.push_back('{data: r2, cnt: 0});
      if (s1w) model_write(s1_addr, s1_be, s1_wd);
      if (s2w && !coll) model_write(s2_addr, s2_be, s2_wd);
      prev_stall = coll;
    end
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    set_idle(); s1_cs = 1; s1_wr = 1; s1_addr = a; s1_be = be; s1_wd = d;
    do_cycle(); set_idle();
  endtask

  task automatic wr2(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    set_idle(); s2_cs = 1; s2_wr = 1; s2_addr = a; s2_be = be; s2_wd = d;
    do_cycle(); set_idle();
  endtask

  task automatic rd1(input logic [12:0] a);
    set_idle(); s1_cs = 1; s1_rd = 1; s1_addr = a;
    do_cycle(); set_idle();
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rdata1"}, s1_readdata, 0);
    check({tag, "_rdata2"}, s2_readdata, 0);
    check({tag, "_valid1"}, s1_readdatavalid, 0);
    check({tag, "_valid2"}, s2_readdatavalid, 0);
    check({tag, "_wait2"}, s2_waitrequest, 0);
    check({tag, "_perr"}, parity_err, 0);
  endtask

  logic [31:0] addr0_val;

  initial begin
    set_idle();
    reset = 1; reset_req = 0; clken = 1; prev_stall = 0;
    last1 = 0; last2 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    check_reset_state("reset");

    // Prefill every word the bench will read in range.
    for (int a = 0; a < 16; a++) wr1(13'(a), 4'hF, $urandom);
    addr0_val = model_mem[0];

    // 1: full write then read, latency 2
    wr1(5, 4'hF, 32'hDEADBEEF);
    last1 = 32'hFFFF_FFFF;
    rd1(5);
    idle(1);
    check("t1_not_early", last1, 32'hFFFF_FFFF);
    idle(1);
    check("t1_readback", last1, 32'hDEADBEEF);

    // 2: byte-lane write from s2
    wr2(5, 4'b0010, 32'h0000AA00);
    rd1(5); idle(3);
    check("t2_readback", last1, 32'hDEADAAEF);

    // 3: same-address collision, s2 held until accepted
    set_idle();
    s1_cs = 1; s1_wr = 1; s1_addr = 7; s1_be = 4'hF; s1_wd = 32'h11;
    s2_cs = 1; s2_wr = 1; s2_addr = 7; s2_be = 4'hF; s2_wd = 32'h22;
    #1; check("t3_stall", s2_waitrequest, 1);
    do_cycle();
    s1_cs = 0; s1_wr = 0;
    #1; check("t3_release", s2_waitrequest, 0);
    do_cycle();
    last1 = 32'hFFFF_FFFF;
    rd1(7); idle(3);
    check("t3_final", last1, 32'h22);

    // 4: out-of-range reads and write
    last1 = 32'hFFFF_FFFF;
    rd1(6000); rd1(8191); idle(3);
    check("t4_oor_data", last1, 0);
    wr1(6000, 4'hF, 32'hCAFEF00D);
    rd1(0); idle(3);
    check("t4_addr0", last1, addr0_val);

    // 5: freeze mid-stream, then reset drops the in-flight read
    rd1(1); rd1(2);
    set_idle(); clken = 0;
    for (int i = 0; i < 3; i++) begin
      #1; check("t5_frozen_valid", s1_readdatavalid, 0);
      do_cycle();
    end
    clken = 1;
    rd1(3); rd1(4); idle(1);
    reset = 1; do_cycle(); reset = 0;
    check_reset_state("t5_reset");
    idle(4);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int k;
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      k = $urandom_range(0, 9);
      s1_cs = (k >= 3); s1_rd = (k >= 3 && k <= 5) || k == 9 || k == 0;
      s1_wr = (k >= 6);
      s1_addr = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(6000, 8191)) :
                (s1_wr ? 13'($urandom_range(0, 3)) : 13'($urandom_range(0, 15)));
      s1_be = 4'($urandom); s1_wd = $urandom;
      if (!prev_stall) begin
        k = $urandom_range(0, 9);
        s2_cs = (k >= 3); s2_rd = (k >= 3 && k <= 5) || k == 9 || k == 1;
        s2_wr = (k >= 6);
        s2_addr = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(6000, 8191)) :
                  (s2_wr ? 13'($urandom_range(0, 3)) : 13'($urandom_range(0, 15)));
        s2_be = 4'($urandom); s2_wd = $urandom;
      end
      do_cycle();
    end
    clken = 1; reset_req = 0;
    idle(4);
    check("rand_q1_drained", q1.size(), 0);
    check("rand_q2_drained", q2.size(), 0);
    check("rand_perr", parity_err, 0);

`ifdef ONCHIP_RAM_PARITY_EN
    // 6: corrupt a stored parity bit and read it back
    wr1(9, 4'hF, 32'h12345678);
    dut.mem[9][DATA_W] = ~dut.mem[9][DATA_W];
    rd1(9); idle(1);
    #1; check("t6_perr_on_valid", parity_err, 1);
    idle(3);
    check("t6_perr_sticky", parity_err, 1);
    reset = 1; do_cycle(); reset = 0;
    check("t6_perr_cleared", parity_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
